// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_pkg: shared constants, FSM encoding and helpers for the UART     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_PUSH   = 3'd5
  } rx_state_e;

  // Never returns less than 1 so it can size a vector directly.
  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic int calc_div(input int base_freq, input int baudrate, input int ovs);
    return (base_freq + (baudrate * ovs) / 2) / (baudrate * ovs);
  endfunction

  function automatic logic maj3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_rx_fifo: synchronous FIFO for received words and error flags    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);

  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             wr_en;
  logic             rd_en;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata = mem_q[rd_ptr_q[AW-1:0]];

  // A simultaneous pop frees the slot the push is about to take.
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + 1'b1 : rd_ptr_q;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_rx_ovs.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_rx_ovs: oversampled UART receiver with majority vote and FIFO   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module uart_rx_ovs
  import uart_pkg::*;
#(
  parameter int BASE_FREQ   = 50000000,
  parameter int BAUDRATE    = 115200,
  parameter int OVERSAMPLE  = 16,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 1,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 serial_in,
  input  logic                 data_ready,
  output logic [DATA_BITS-1:0] parallel_out,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 break_det,
  output logic                 busy
);

  localparam int DIV   = calc_div(BASE_FREQ, BAUDRATE, OVERSAMPLE);
  localparam int DIV_W = clog2(DIV);
  localparam int OVS_W = clog2(OVERSAMPLE);
  localparam int BIT_W = clog2(DATA_BITS);
  localparam int WIDTH = DATA_BITS + 2;

  logic [1:0]           sync_q, sync_d;
  rx_state_e            state_q, state_d;
  logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
  logic [OVS_W-1:0]     ovs_cnt_q, ovs_cnt_d;
  logic [2:0]           samp_q, samp_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 par_bit_q, par_bit_d;
  logic                 stop1z_q, stop1z_d;
  logic                 break_q, break_d;
  logic                 busy_q, busy_d;
  logic                 overrun_q, overrun_d;

  logic             rx_s;
  logic             tick, bit_end, mid_end, samp_win;
  logic [2:0]       samp_now;
  logic             par_exp, brk_frame;
  logic             push, pop, fifo_empty, fifo_full;
  logic [WIDTH-1:0] fifo_rdata;

  assign rx_s     = sync_q[1];
  assign tick     = (div_cnt_q == DIV_W'(DIV - 1));
  assign bit_end  = tick && (ovs_cnt_q == OVS_W'(OVERSAMPLE - 1));
  assign mid_end  = tick && (ovs_cnt_q == OVS_W'(OVERSAMPLE / 2 + 1));
  assign samp_win = (ovs_cnt_q >= OVS_W'(OVERSAMPLE / 2 - 1)) &&
                    (ovs_cnt_q <= OVS_W'(OVERSAMPLE / 2 + 1));
  // At the third sample tick the newest sample is still on rx_s.
  assign samp_now = {samp_q[1:0], rx_s};
  assign par_exp  = (PARITY_MODE == PARITY_ODD) ? ~^shift_q : ^shift_q;
  assign brk_frame = (shift_q == '0) && stop1z_q &&
                     ((PARITY_MODE == PARITY_NONE) || !par_bit_q);
  assign push     = (state_q == ST_PUSH);

  always_comb begin
    sync_d     = {sync_q[0], serial_in};
    state_d    = state_q;
    div_cnt_d  = tick ? '0 : div_cnt_q + 1'b1;
    ovs_cnt_d  = ovs_cnt_q;
    samp_d     = samp_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    shift_d    = shift_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    par_bit_d  = par_bit_q;
    stop1z_d   = stop1z_q;
    break_d    = break_q;
    if (tick) ovs_cnt_d = (ovs_cnt_q == OVS_W'(OVERSAMPLE - 1)) ? '0 : ovs_cnt_q + 1'b1;
    if (tick && samp_win) samp_d = samp_now;

    case (state_q)
      ST_IDLE: begin
        if (!rx_s && !break_q) begin
          state_d    = ST_START;
          div_cnt_d  = '0;
          ovs_cnt_d  = '0;
          bit_cnt_d  = '0;
          stop_cnt_d = 1'b0;
          perr_d     = 1'b0;
          ferr_d     = 1'b0;
          par_bit_d  = 1'b0;
          stop1z_d   = 1'b0;
        end
      end
      ST_START: begin
        if (mid_end && maj3(samp_now)) state_d = ST_IDLE;
        else if (bit_end)              state_d = ST_DATA;
      end
      ST_DATA: begin
        if (bit_end) begin
          shift_d   = {maj3(samp_q), shift_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BIT_W'(DATA_BITS - 1))
            state_d = (PARITY_MODE == PARITY_NONE) ? ST_STOP : ST_PARITY;
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          par_bit_d = maj3(samp_q);
          perr_d    = (maj3(samp_q) != par_exp);
          state_d   = ST_STOP;
        end
      end
      ST_STOP: begin
        // Leave at mid-bit so a following start edge is never missed.
        if (mid_end) begin
          if (!maj3(samp_now)) ferr_d = 1'b1;
          if (!stop_cnt_q) stop1z_d = !maj3(samp_now);
          if (stop_cnt_q == 1'(STOP_BITS - 1)) state_d = ST_PUSH;
          else                                 stop_cnt_d = 1'b1;
        end
      end
      ST_PUSH: begin
        state_d = ST_IDLE;
        if (brk_frame && !rx_s) break_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (break_q && rx_s) break_d = 1'b0;
    busy_d    = (state_d != ST_IDLE);
    overrun_d = push && fifo_full && !pop;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q     <= 2'b11;
      state_q    <= ST_IDLE;
      div_cnt_q  <= '0;
      ovs_cnt_q  <= '0;
      samp_q     <= 3'b111;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      shift_q    <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      par_bit_q  <= 1'b0;
      stop1z_q   <= 1'b0;
      break_q    <= 1'b0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      ovs_cnt_q  <= ovs_cnt_d;
      samp_q     <= samp_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      shift_q    <= shift_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      par_bit_q  <= par_bit_d;
      stop1z_q   <= stop1z_d;
      break_q    <= break_d;
      busy_q     <= busy_d;
      overrun_q  <= overrun_d;
    end
  end

  uart_rx_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({ferr_q, perr_q, shift_q}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign data_valid   = !fifo_empty;
  assign pop          = data_valid && data_ready;
  assign parallel_out = data_valid ? fifo_rdata[DATA_BITS-1:0] : '0;
  assign parity_err   = data_valid && fifo_rdata[DATA_BITS];
  assign frame_err    = data_valid && fifo_rdata[DATA_BITS+1];
  assign overrun      = overrun_q;
  assign break_det    = break_q;
  assign busy         = busy_q;

endmodule
`default_nettype wire
